// File: rtl/hall_period_meter.sv
// Hall sensor period meter: counts clk cycles between accepted rising edges of hall_in.
// Optional glitch filter on the synchronized input is enabled by defining HALL_FILTER_EN.
module hall_period_meter #(
  parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2 * SYS_CLK_FREQ,
  parameter int unsigned PW             = 32,
  parameter int unsigned FILT_LEN       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hall_in,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          edge_pulse,
  output logic          stalled
);

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } state_e;

  localparam logic [PW-1:0] TimeoutVal = PW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] CntOne     = PW'(1);

  // The timeout must be representable so the counter can never wrap.
  if (FILT_LEN == 0 || (64'(1) << PW) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("hall_period_meter: need FILT_LEN >= 1 and 2**PW > TIMEOUT_CYCLES");
  end

  logic          s1;
  logic          s2;
  logic          f;
  logic          f_d;
  logic          rise;
  logic [PW-1:0] cnt;
  state_e        state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= hall_in;
      s2 <= s1;
    end
  end

`ifdef HALL_FILTER_EN
  localparam int unsigned FcW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FcW-1:0] filt_cnt;

  // f follows s2 only after s2 has disagreed with it for FILT_LEN straight cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f        <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 == f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FcW'(FILT_LEN - 1)) begin
      f        <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FcW'(1);
    end
  end
`else
  assign f = s2;
`endif

  assign rise = f & ~f_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_d          <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      edge_pulse   <= 1'b0;
      stalled      <= 1'b1;
      state        <= StIdle;
    end else begin
      f_d          <= f;
      edge_pulse   <= rise;
      period_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          // First edge only arms the measurement.
          if (rise) begin
            cnt   <= CntOne;
            state <= StMeasure;
          end
        end
        StMeasure: begin
          // An edge on the timeout cycle still counts as a valid period.
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            stalled      <= 1'b0;
            cnt          <= CntOne;
          end else if (cnt == TimeoutVal) begin
            period       <= '0;
            period_valid <= 1'b1;
            stalled      <= 1'b1;
            cnt          <= '0;
            state        <= StIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_period_meter.sv
// Directed bench for hall_period_meter: reset, steady train, stall, timeout boundary,
// mid-measurement reset and glitch handling (expectations follow HALL_FILTER_EN).
module tb_hall_period_meter;

  localparam int unsigned Timeout = 1000;
  localparam int unsigned Pw      = 16;
  localparam int unsigned FiltLen = 4;
`ifdef HALL_FILTER_EN
  localparam int unsigned Lat = 3 + FiltLen;
`else
  localparam int unsigned Lat = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hall_in = 1'b0;
  logic [Pw-1:0] period;
  logic          period_valid;
  logic          edge_pulse;
  logic          stalled;

  logic [31:0] cyc = '0;
  logic [31:0] ep_t [$];
  logic [31:0] pv_t [$];
  logic [31:0] pv_p [$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  hall_period_meter #(
    .SYS_CLK_FREQ  (100_000_000),
    .TIMEOUT_CYCLES(Timeout),
    .PW            (Pw),
    .FILT_LEN      (FiltLen)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hall_in     (hall_in),
    .period      (period),
    .period_valid(period_valid),
    .edge_pulse  (edge_pulse),
    .stalled     (stalled)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (edge_pulse) ep_t.push_back(cyc);
    if (period_valid) begin
      pv_t.push_back(cyc);
      pv_p.push_back(32'(period));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    if (i >= q.size()) return 32'hFFFF_FFFF;
    return q[i];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hall_in = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
  endtask

  int          e0;
  int          p0;
  logic [31:0] rt [5];
  logic [31:0] t0;

  initial begin
    // Scenario 1: held in reset while hall_in toggles.
    step(1);
    for (int i = 0; i < 8; i++) begin
      hall_in = ~hall_in;
      step(2);
      check("rst_period", 32'(period), 32'd0);
      check("rst_pv", 32'(period_valid), 32'd0);
      check("rst_ep", 32'(edge_pulse), 32'd0);
      check("rst_stalled", 32'(stalled), 32'd1);
    end
    hall_in = 1'b0;
    step(3);
    rst = 1'b0;
    step(3);
    p0 = pv_t.size();
    hall_in = 1'b1;
    step(Lat - 1);
    check("s1_ep_early", 32'(edge_pulse), 32'd0);
    step(1);
    check("s1_ep", 32'(edge_pulse), 32'd1);
    check("s1_pv", 32'(period_valid), 32'd0);
    check("s1_stalled", 32'(stalled), 32'd1);
    step(1);
    check("s1_ep_one_cycle", 32'(edge_pulse), 32'd0);
    step(50);
    hall_in = 1'b0;
    step(20);
    check("s1_no_pv", 32'(pv_t.size() - p0), 32'd0);

    // Scenario 2: five rises every 250 cycles.
    do_reset();
    e0 = ep_t.size();
    p0 = pv_t.size();
    for (int i = 0; i < 5; i++) begin
      rt[i] = cyc;
      hall_in = 1'b1;
      if (i == 1) begin
        step(Lat - 1);
        check("s2_stalled_pre", 32'(stalled), 32'd1);
        step(1);
        check("s2_stalled_drop", 32'(stalled), 32'd0);
        check("s2_pv_first", 32'(period_valid), 32'd1);
        check("s2_period_first", 32'(period), 32'd250);
        step(100 - Lat);
      end else begin
        step(100);
      end
      hall_in = 1'b0;
      step(150);
    end
    check("s2_ep_count", 32'(ep_t.size() - e0), 32'd5);
    check("s2_pv_count", 32'(pv_t.size() - p0), 32'd4);
    for (int i = 0; i < 5; i++) check("s2_ep_latency", q_at(ep_t, e0 + i), rt[i] + Lat);
    for (int i = 0; i < 4; i++) check("s2_period", q_at(pv_p, p0 + i), 32'd250);
    check("s2_stalled_end", 32'(stalled), 32'd0);

    // Scenario 3: stall after 300, then re-arm and measure 400.
    do_reset();
    e0 = ep_t.size();
    p0 = pv_t.size();
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(200);
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(Lat + 899);
    check("s3_pre_timeout_pv", 32'(period_valid), 32'd0);
    check("s3_pre_timeout_stalled", 32'(stalled), 32'd0);
    step(1);
    check("s3_timeout_pv", 32'(period_valid), 32'd1);
    check("s3_timeout_period", 32'(period), 32'd0);
    check("s3_timeout_stalled", 32'(stalled), 32'd1);
    step(1);
    check("s3_timeout_pv_one", 32'(period_valid), 32'd0);
    step(50);
    check("s3_first_period", q_at(pv_p, p0), 32'd300);
    check("s3_timeout_gap", q_at(pv_t, p0 + 1) - q_at(ep_t, e0 + 1), 32'd1000);
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(300);
    check("s3_rearm_no_pv", 32'(pv_t.size() - p0), 32'd2);
    check("s3_rearm_stalled", 32'(stalled), 32'd1);
    hall_in = 1'b1;
    step(Lat);
    check("s3_pv_400", 32'(period_valid), 32'd1);
    check("s3_period_400", 32'(period), 32'd400);
    check("s3_stalled_400", 32'(stalled), 32'd0);
    step(100 - Lat);
    hall_in = 1'b0;
    step(20);

    // Scenario 4: second edge lands on the timeout cycle.
    do_reset();
    p0 = pv_t.size();
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(900);
    hall_in = 1'b1;
    step(Lat);
    check("s4_pv", 32'(period_valid), 32'd1);
    check("s4_period_1000", 32'(period), 32'd1000);
    check("s4_stalled", 32'(stalled), 32'd0);
    step(100 - Lat);
    hall_in = 1'b0;
    step(400);
    hall_in = 1'b1;
    step(Lat);
    check("s4_still_measure", 32'(period), 32'd500);
    step(100 - Lat);
    hall_in = 1'b0;
    step(10);
    check("s4_pv_count", 32'(pv_t.size() - p0), 32'd2);

    // Scenario 5: asynchronous reset mid-measurement.
    do_reset();
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(100);
    hall_in = 1'b1;
    step(Lat);
    check("s5_period_200", 32'(period), 32'd200);
    step(100 - Lat);
    hall_in = 1'b0;
    step(Lat);
    #3;
    rst = 1'b1;
    #1;
    check("s5_rst_period", 32'(period), 32'd0);
    check("s5_rst_stalled", 32'(stalled), 32'd1);
    check("s5_rst_pv", 32'(period_valid), 32'd0);
    check("s5_rst_ep", 32'(edge_pulse), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);
    p0 = pv_t.size();
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(400);
    hall_in = 1'b1;
    step(Lat);
    check("s5_period_500", 32'(period), 32'd500);
    step(100 - Lat);
    hall_in = 1'b0;
    step(10);
    check("s5_pv_count", 32'(pv_t.size() - p0), 32'd1);

    // Scenario 6: 2-cycle glitches between 250-cycle edges.
    do_reset();
    e0 = ep_t.size();
    p0 = pv_t.size();
    t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      hall_in = 1'b1;
      step(100);
      hall_in = 1'b0;
      step(50);
      hall_in = 1'b1;
      step(2);
      hall_in = 1'b0;
      step(98);
    end
    hall_in = 1'b1;
    step(100);
    hall_in = 1'b0;
    step(20);
    check("s6_first_ep", q_at(ep_t, e0), t0 + Lat);
`ifdef HALL_FILTER_EN
    check("s6_ep_count", 32'(ep_t.size() - e0), 32'd3);
    check("s6_pv_count", 32'(pv_t.size() - p0), 32'd2);
    for (int i = 0; i < 2; i++) check("s6_period", q_at(pv_p, p0 + i), 32'd250);
`else
    check("s6_ep_count", 32'(ep_t.size() - e0), 32'd5);
    check("s6_pv_count", 32'(pv_t.size() - p0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("s6_period", q_at(pv_p, p0 + i), (i % 2 == 0) ? 32'd150 : 32'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hall_period_meter.md
Name: hall_period_meter

Overview:
Measures the interval between consecutive rising edges of the raw Hall-effect sensor input, in system-clock cycles. It is the inverse of the tick divider: the divider turns a cycle count into a pulse, and this block turns a pulse train back into a cycle count. Output is a registered period word with a one-cycle valid strobe, plus a stall flag, feeding the RPM computation stage. It sits between the board-level Hall input pin and the RPM arithmetic and display logic.

Parameters:
SYS_CLK_FREQ, 100_000_000, clk frequency in Hz (documentation and default derivation only)
TIMEOUT_CYCLES, 200_000_000, cycles without an edge before the rotor is declared stalled (default 2 s)
PW, 32, width of period counter and output; must satisfy 2^PW > TIMEOUT_CYCLES
FILT_LEN, 4, glitch-filter stability length in cycles (used only with HALL_FILTER_EN)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
hall_in  input  1  raw Hall sensor level, asynchronous to clk
period  output  PW  last measured edge-to-edge interval in clk cycles; 0 means stalled
period_valid  output  1  one-cycle strobe; period updated this cycle
edge_pulse  output  1  one-cycle strobe per accepted rising edge
stalled  output  1  high while no valid measurement is in progress

Behaviour:
- Reset is asynchronous, active-high, on clk domain. All flops clear on reset.
- Reset values: period=0, period_valid=0, edge_pulse=0, stalled=1, state=IDLE, cnt=0, synchronizer flops=0.
- Input path: two-flop synchronizer (s1, s2), then the filtered level f, then a delay flop f_d. Rising edge is defined as f & ~f_d.
- Without the filter, f=s2. edge_pulse and period_valid are registered. Latency from a hall_in rise sampled at cycle T to edge_pulse is cycle T+3.
- Counter cnt, PW bits:
  - On each accepted edge, cnt is loaded with 1.
  - Otherwise, in MEASURE, cnt increments by 1.
  - At edge E2, N cycles after edge E1, cnt holds exactly N.
- State IDLE:
  - Accepted edge: load cnt=1, go to MEASURE, pulse edge_pulse. No period_valid is issued (the first edge only arms the measurement). stalled stays 1.
- State MEASURE, accepted edge:
  - period<=cnt, period_valid=1 for one cycle, edge_pulse=1, stalled<=0, cnt<=1, remain in MEASURE.
- State MEASURE, timeout:
  - If cnt==TIMEOUT_CYCLES and there is no edge this cycle: period<=0, period_valid=1 for one cycle, stalled<=1, cnt<=0, go to IDLE.
- Simultaneous edge and timeout on the same cycle: the edge wins. period=TIMEOUT_CYCLES is reported and the block stays in MEASURE.
- The counter never wraps, because the timeout caps it below 2^PW.
- A falling edge has no effect on the measurement.
- A constant-high or constant-low input produces no edges and leads to stall via timeout.
- period holds its value between strobes. Consumers sample it only on period_valid.
- Reset asserted mid-measurement: everything returns to its reset value immediately. The first edge after reset only re-arms the block.

Optional Feature:
Macro HALL_FILTER_EN.
- Defined: f changes to the level of s2 only after s2 has held that level for FILT_LEN consecutive cycles, using a filter counter that restarts on any mismatch. Pulses shorter than FILT_LEN cycles are ignored entirely. Latency from hall_in to edge_pulse becomes T+3+FILT_LEN. Measured periods are unchanged in steady state, because every edge sees the same delay.
- Undefined: f=s2, no filter logic is present, and the FILT_LEN parameter is unused.

Test Plan:
Bench parameters for all scenarios: TIMEOUT_CYCLES=1000, PW=16.
1. Reset: rst high, hall_in toggling -> period=0, period_valid=0, edge_pulse=0, stalled=1 throughout; after release, the first rise gives edge_pulse only, with no period_valid.
2. Steady train: rising edges every 250 cycles, 5 edges -> 4 period_valid strobes, each with period=250; stalled drops to 0 with the first strobe; edge_pulse appears 3 cycles after each hall_in rise.
3. Stall: edges at 0 and 300, then hall_in held low -> period=300 strobe, then exactly 1000 cycles after the last edge a strobe with period=0 and stalled=1; the next rise gives edge_pulse only, and the following rise 400 cycles later gives period=400.
4. Boundary: second edge arrives exactly when cnt==1000 -> period=1000 reported, stalled=0, state remains MEASURE.
5. Mid-measurement reset: rst pulsed 100 cycles after an edge -> all outputs return to reset values; next two rises 500 cycles apart yield a single period=500.
6. Filter (HALL_FILTER_EN, FILT_LEN=4): 2-cycle high glitches between 250-cycle edges -> no extra edge_pulse, periods remain 250. Without the macro, the same stimulus produces extra edge_pulse strobes and short periods.
